prm_edge_mask_engine: RTL and testbench
=======================================

PRM_EDGE_MASK_ENGINE -- requirements
Module: prm_edge_mask_engine

Interface
REQ-001 SHALL have parameter IN_W, default 15, meaning configuration-word width (inputs A..O, A = bit 0).
REQ-002 SHALL have parameter N_CH, default 4, meaning number of obstacle channels; each channel produces one edge-mask bit.
REQ-003 SHALL have parameter N_TERMS, default 16, meaning product-term slots per channel.
REQ-004 SHALL have parameter LANES, default 4, meaning terms evaluated per channel per cycle; N_TERMS SHALL be a multiple of LANES.
REQ-005 SHALL have these ports:
 - clk  in  1  single clock, rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - prog_valid  in  1  term-write request.
 - prog_ready  out  1  term write accepted this cycle.
 - prog_ch  in  clog2(N_CH)  target channel.
 - prog_idx  in  clog2(N_TERMS)  target term slot.
 - prog_care  in  IN_W  care mask; 1 = literal present.
 - prog_val  in  IN_W  required literal values.
 - prog_en  in  1  term enable.
 - in_valid  in  1  query configuration valid.
 - in_ready  out  1  query accepted.
 - in_cfg  in  IN_W  configuration word.
 - out_valid  out  1  result valid.
 - out_ready  in  1  result consumed.
 - out_mask  out  N_CH  per-channel edge mask.
 - busy  out  1  state is not IDLE.

Function
REQ-006 SHALL store N_CH x N_TERMS terms in flops, each term holding {care, val, en}.
REQ-007 SHALL define a term hit as en=1 and ((cfg XOR val) AND care)=0; a channel bit is the OR of its term hits (sum of products).
REQ-008 SHALL use states IDLE, SCAN and DONE.
REQ-009 SHALL drive prog_ready = (state==IDLE); a write occurs when prog_valid and prog_ready are both 1 and takes effect for the next query.
REQ-010 SHALL drive in_ready = (state==IDLE) AND NOT prog_valid; programming has priority over a query in the same cycle.
REQ-011 On in_valid&&in_ready, SHALL latch in_cfg, clear the accumulators and the scan counter, and go to SCAN.
REQ-012 In SCAN, SHALL evaluate slots [k*LANES, k*LANES+LANES-1] of every channel in cycle k and OR the results into the accumulators.
REQ-013 SHALL go SCAN->DONE after scan cycle N_TERMS/LANES-1; out_valid SHALL be 1 in the first DONE cycle, giving N_TERMS/LANES+1 cycles from accept to out_valid.
REQ-014 In DONE, SHALL hold out_valid and out_mask stable until out_ready=1, then go to IDLE; in_ready SHALL be 0 during the out_ready cycle (no back-to-back accept).
REQ-015 out_mask SHALL equal the accumulators while in DONE and SHALL keep its last value in other states.
REQ-016 A disabled term (en=0) SHALL never hit; care=0 with en=1 SHALL always hit.

Reset
REQ-017 rst SHALL asynchronously force state=IDLE, all term en bits=0, accumulators=0, out_mask=0, out_valid=0 and the scan counter=0.
REQ-018 Reset asserted during SCAN or DONE SHALL discard the in-flight query; in_ready and prog_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-019 Macro PRM_EARLY_EXIT_EN defined: SHALL go SCAN->DONE in the cycle after the accumulators become all ones, skipping the remaining scan cycles.
REQ-020 Macro PRM_EARLY_EXIT_EN undefined: SHALL always scan all N_TERMS/LANES cycles; latency is fixed per REQ-013.

Verification (IN_W=15, N_CH=4, N_TERMS=16, LANES=4)
REQ-021 After reset, query cfg=15'h7FFF -> out_valid asserted 5 cycles after accept with out_mask=4'b0000.
REQ-022 Program ch2 idx13 care=15'h4000 val=15'h4000 en=1; query cfg=15'h4000 -> out_mask=4'b0100; query cfg=15'h0000 -> out_mask=4'b0000.
REQ-023 Assert prog_valid and in_valid in the same IDLE cycle -> write accepted, in_ready=0; the query is accepted the next cycle and sees the new term.
REQ-024 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_mask stable; in_ready=0 and prog_ready=0 throughout.
REQ-025 Program idx0 of all 4 channels with care=0, en=1; query -> out_mask=4'hF, with latency 2 cycles if PRM_EARLY_EXIT_EN is defined and 5 cycles if it is not.
REQ-026 Assert rst during scan cycle 2 -> out_valid=0 and all terms disabled; a following query returns 4'b0000.

Source files
------------

// File: rtl/prm_edge_mask_engine.sv
`timescale 1ns/1ps
// prm_edge_mask_engine
// ---------------------------------------------------------------------------
// Purpose: programmable sum-of-products edge-mask engine. Each of N_CH
// obstacle channels holds N_TERMS product terms {care, val, en}. A query
// configuration word is scanned LANES terms per channel per cycle. Each
// channel's result bit is the OR of its term hits.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   prog_valid/prog_ready    term write handshake (accepted only in IDLE)
//   prog_ch, prog_idx        target channel / term slot of a write
//   prog_care, prog_val,     term contents (care mask, literal values,
//   prog_en                  enable)
//   in_valid/in_ready        query handshake, in_cfg is the configuration word
//   out_valid/out_ready      result handshake, out_mask is the per-channel mask
//   busy                     engine is not idle
//
// Optional feature: define PRM_EARLY_EXIT_EN to leave the scan as soon as
// every channel has already hit. Without it, latency is always
// N_TERMS/LANES+1 cycles from accept to out_valid.
// ---------------------------------------------------------------------------
module prm_edge_mask_engine #(
  parameter int IN_W    = 15,
  parameter int N_CH    = 4,
  parameter int N_TERMS = 16,
  parameter int LANES   = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_valid,
  output logic             prog_ready,
  input  logic [CH_W-1:0]  prog_ch,
  input  logic [IDX_W-1:0] prog_idx,
  input  logic [IN_W-1:0]  prog_care,
  input  logic [IN_W-1:0]  prog_val,
  input  logic             prog_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_cfg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_CH-1:0]  out_mask,
  output logic             busy
);

  localparam int N_SCAN = N_TERMS / LANES;
  localparam int CNT_W  = $clog2(N_SCAN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] scan_cnt;
  logic [IN_W-1:0]  cfg_q;
  logic [N_CH-1:0]  acc;
  logic [N_CH-1:0]  scan_hits;
  logic [N_CH-1:0]  mask_q;
  logic [IDX_W-1:0] slot;
  logic             early_exit;
  logic             scan_done;

  logic [IN_W-1:0]  term_care [N_CH][N_TERMS];
  logic [IN_W-1:0]  term_val  [N_CH][N_TERMS];
  logic             term_en   [N_CH][N_TERMS];

  assign prog_ready = (state == S_IDLE);
  assign in_ready   = (state == S_IDLE) && !prog_valid;
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_mask   = mask_q;

`ifdef PRM_EARLY_EXIT_EN
  assign early_exit = &acc;
`else
  assign early_exit = 1'b0;
`endif

  // The counter runs one step past the last lane group. That final SCAN
  // cycle evaluates nothing. It only lets the last group's hits settle into
  // the accumulators before DONE.
  assign scan_done = (scan_cnt == CNT_W'(N_SCAN)) || early_exit;

  // Term storage. Writes land only while idle, so a running scan never sees
  // a half-updated term set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int t = 0; t < N_TERMS; t++) begin
          term_care[c][t] <= '0;
          term_val[c][t]  <= '0;
          term_en[c][t]   <= 1'b0;
        end
      end
    end else if (prog_valid && prog_ready &&
                 (int'(prog_ch) < N_CH) && (int'(prog_idx) < N_TERMS)) begin
      term_care[prog_ch][prog_idx] <= prog_care;
      term_val[prog_ch][prog_idx]  <= prog_val;
      term_en[prog_ch][prog_idx]   <= prog_en;
    end
  end

  // Evaluate the current lane group of every channel against the latched
  // configuration.
  always_comb begin
    scan_hits = '0;
    slot      = '0;
    if ((state == S_SCAN) && (scan_cnt < CNT_W'(N_SCAN))) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int l = 0; l < LANES; l++) begin
          slot = IDX_W'(int'(scan_cnt) * LANES + l);
          if (term_en[c][slot] &&
              (((cfg_q ^ term_val[c][slot]) & term_care[c][slot]) == '0)) begin
            scan_hits[c] = 1'b1;
          end
        end
      end
    end
  end

  // Control FSM. It accepts a query, scans the lane groups, then holds the
  // result until it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      scan_cnt <= '0;
      cfg_q    <= '0;
      acc      <= '0;
      mask_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cfg_q    <= in_cfg;
            acc      <= '0;
            scan_cnt <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc <= acc | scan_hits;
          if (scan_done) begin
            mask_q <= acc;
            state  <= S_DONE;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
`timescale 1ns/1ps
// tb_prm_edge_mask_engine
// ---------------------------------------------------------------------------
// Purpose: self-checking bench for prm_edge_mask_engine. Queries push their
// expected mask and latency into a scoreboard when accepted. A monitor pops
// and compares whenever the engine presents a result. Expected values come
// from a term-table model that applies the hit rule directly.
// Ports: none (top-level bench). Honours PRM_EARLY_EXIT_EN for latency.
// ---------------------------------------------------------------------------
module tb_prm_edge_mask_engine;

  localparam int IN_W    = 15;
  localparam int N_CH    = 4;
  localparam int N_TERMS = 16;
  localparam int LANES   = 4;
  localparam int N_SCAN  = N_TERMS / LANES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            prog_valid = 1'b0;
  logic            prog_ready;
  logic [1:0]      prog_ch = '0;
  logic [3:0]      prog_idx = '0;
  logic [IN_W-1:0] prog_care = '0;
  logic [IN_W-1:0] prog_val = '0;
  logic            prog_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_cfg = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N_CH-1:0] out_mask;
  logic            busy;

  prm_edge_mask_engine #(
    .IN_W(IN_W), .N_CH(N_CH), .N_TERMS(N_TERMS), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_ch(prog_ch), .prog_idx(prog_idx),
    .prog_care(prog_care), .prog_val(prog_val), .prog_en(prog_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_cfg(in_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N_CH-1:0] mask;
    int              acc_cyc;
    int              lat;
  } exp_t;
  exp_t sb[$];

  logic [IN_W-1:0] m_care [N_CH][N_TERMS];
  logic [IN_W-1:0] m_val  [N_CH][N_TERMS];
  bit              m_en   [N_CH][N_TERMS];

  bit              mon_open = 1'b0;
  logic [N_CH-1:0] mon_mask = '0;

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit term_hits(input int c, input int t, input logic [IN_W-1:0] cfg);
    return m_en[c][t] && (((cfg ^ m_val[c][t]) & m_care[c][t]) == '0);
  endfunction

  function automatic logic [N_CH-1:0] model_mask(input logic [IN_W-1:0] cfg);
    logic [N_CH-1:0] m = '0;
    for (int c = 0; c < N_CH; c++)
      for (int t = 0; t < N_TERMS; t++)
        if (term_hits(c, t, cfg)) m[c] = 1'b1;
    return m;
  endfunction

  // Cycles from accept to out_valid. The early-exit build stops one cycle
  // after the first lane group that completes full coverage.
  function automatic int model_latency(input logic [IN_W-1:0] cfg);
`ifdef PRM_EARLY_EXIT_EN
    logic [N_CH-1:0] seen = '0;
    for (int g = 0; g < N_SCAN; g++) begin
      for (int c = 0; c < N_CH; c++)
        for (int t = g * LANES; t < (g + 1) * LANES; t++)
          if (term_hits(c, t, cfg)) seen[c] = 1'b1;
      if (&seen) return (g + 2 < N_SCAN + 1) ? g + 2 : N_SCAN + 1;
    end
    return N_SCAN + 1;
`else
    return N_SCAN + 1 + 0 * int'(cfg[0]);
`endif
  endfunction

  // Scoreboard monitor, sampling on the falling edge. When a result first
  // appears, it is popped and checked. It must then stay stable until
  // consumed.
  always @(negedge clk) begin
    if (rst) begin
      mon_open = 1'b0;
    end else if (out_valid) begin
      if (!mon_open) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_result: got mask 0x%0h with empty scoreboard", out_mask);
        end else begin
          exp_t e;
          e = sb.pop_front();
          mon_mask = e.mask;
          compareVal("out_mask", 32'(out_mask), 32'(e.mask));
          compareVal("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        mon_open = 1'b1;
      end else begin
        compareVal("mask_stable", 32'(out_mask), 32'(mon_mask));
      end
      if (out_ready) mon_open = 1'b0;
    end
  end

  // Drive an optional term write and/or an optional query. Keep them
  // asserted until each handshake completes, and update the model on accept.
  task automatic applyStimulus(input bit dp, input int ch, input int idx,
                               input logic [IN_W-1:0] care, input logic [IN_W-1:0] val,
                               input bit en, input bit dq, input logic [IN_W-1:0] cfg);
    bit p_done;
    bit q_done;
    int guard;
    p_done = !dp;
    q_done = !dq;
    @(posedge clk); #1;
    prog_valid = dp;
    prog_ch    = 2'(ch);
    prog_idx   = 4'(idx);
    prog_care  = care;
    prog_val   = val;
    prog_en    = en;
    in_valid   = dq;
    in_cfg     = cfg;
    guard = 0;
    while (!(p_done && q_done) && guard < 50) begin
      @(negedge clk);
      if (prog_valid) begin
        if (in_valid) compareVal("in_ready_prio", 32'(in_ready), 32'd0);
        if (prog_ready) begin
          m_care[ch][idx] = care;
          m_val[ch][idx]  = val;
          m_en[ch][idx]   = en;
          p_done = 1'b1;
        end
      end else if (in_valid && in_ready) begin
        exp_t e;
        e.mask    = model_mask(cfg);
        e.acc_cyc = cyc + 1;
        e.lat     = model_latency(cfg);
        sb.push_back(e);
        q_done = 1'b1;
      end
      @(posedge clk); #1;
      if (p_done) prog_valid = 1'b0;
      if (q_done) in_valid = 1'b0;
      guard++;
    end
    if (guard >= 50) compareVal("handshake_timeout", 32'd1, 32'd0);
  endtask

  // Wait for a result. Hold it for `hold` cycles while checking the
  // handshake flags, then consume it.
  task automatic checkOutput(input int hold);
    int guard;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid) begin
      compareVal("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      compareVal("hold_out_valid", 32'(out_valid), 32'd1);
      compareVal("hold_in_ready", 32'(in_ready), 32'd0);
      compareVal("hold_prog_ready", 32'(prog_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    compareVal("in_ready_consume", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    compareVal("idle_after_consume", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    sb.delete();
    for (int c = 0; c < N_CH; c++)
      for (int t = 0; t < N_TERMS; t++) begin
        m_care[c][t] = '0;
        m_val[c][t]  = '0;
        m_en[c][t]   = 1'b0;
      end
    #1;
    compareVal("rst_out_valid", 32'(out_valid), 32'd0);
    compareVal("rst_out_mask", 32'(out_mask), 32'd0);
    compareVal("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compareVal("post_rst_in_ready", 32'(in_ready), 32'd1);
    compareVal("post_rst_prog_ready", 32'(prog_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [IN_W-1:0] rc;
    doReset();

    // Empty term table: nothing hits.
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h7FFF);
    checkOutput(0);

    // Single literal term on channel 2.
    applyStimulus(1, 2, 13, 15'h4000, 15'h4000, 1, 0, '0);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h4000);
    checkOutput(0);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h0000);
    checkOutput(0);

    // Write and query in the same cycle: the write wins, and the query then
    // sees it.
    applyStimulus(1, 1, 0, 15'h0001, 15'h0001, 1, 1, 15'h0001);
    checkOutput(0);

    // Long backpressure in DONE.
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h4001);
    checkOutput(10);

    // Reset in the middle of a scan discards the query and all terms.
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h4000);
    @(posedge clk);
    @(posedge clk); #3;
    compareVal("busy_in_scan", 32'(busy), 32'd1);
    doReset();
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h4000);
    checkOutput(0);

    // Don't-care terms in slot 0 of every channel hit unconditionally.
    for (int c = 0; c < N_CH; c++)
      applyStimulus(1, c, 0, 15'h0000, 15'h0000, 1, 0, '0);
    applyStimulus(0, 0, 0, '0, '0, 0, 1, 15'h2A5C);
    checkOutput(0);
    for (int c = 0; c < N_CH; c++)
      applyStimulus(1, c, 0, 15'h0000, 15'h0000, 0, 0, '0);

    // Randomized programming and queries.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++)
        applyStimulus(1, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, N_TERMS - 1)),
                      15'($urandom & $urandom & $urandom), 15'($urandom),
                      bit'($urandom_range(0, 3) != 0), 0, '0);
      if ($urandom_range(0, 1) == 1)
        rc = m_val[$urandom_range(0, N_CH - 1)][$urandom_range(0, N_TERMS - 1)];
      else
        rc = 15'($urandom);
      if ($urandom_range(0, 4) == 0)
        applyStimulus(1, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, N_TERMS - 1)),
                      15'($urandom & $urandom), 15'($urandom), 1, 1, rc);
      else
        applyStimulus(0, 0, 0, '0, '0, 0, 1, rc);
      checkOutput(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    compareVal("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
